// File: rtl/vigna_clint_pkg.sv
// Shared definitions for the vigna CLINT: register offsets, decoded register
// select and the byte-lane write merge helper.
package vigna_clint_pkg;

    // Register offsets within the 64 KiB CLINT window (addr[15:0])
    localparam logic [15:0] CLINT_MSIP        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MSIP,
        SEL_CMP_LO,
        SEL_CMP_HI,
        SEL_TIME_LO,
        SEL_TIME_HI
    } clint_sel_e;

    // Word-aligned offset to register select; anything unmapped is SEL_NONE
    function automatic clint_sel_e clint_decode(input logic [15:0] off);
        clint_sel_e sel;
        case (off)
            CLINT_MSIP:        sel = SEL_MSIP;
            CLINT_MTIMECMP_LO: sel = SEL_CMP_LO;
            CLINT_MTIMECMP_HI: sel = SEL_CMP_HI;
            CLINT_MTIME_LO:    sel = SEL_TIME_LO;
            CLINT_MTIME_HI:    sel = SEL_TIME_HI;
            default:           sel = SEL_NONE;
        endcase
        return sel;
    endfunction

    // Replace only the byte lanes whose strobe is set
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/vigna_clint.sv
// Machine timer / software interrupt source for the vigna core. Slave on the
// core's valid/ready data bus with a fixed one-cycle response latency.
module vigna_clint
    import vigna_clint_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    output logic        ready,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic        timer_irq,
    output logic        soft_irq
);

    logic        r_ready;
    logic [31:0] r_rdata;
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_msip;
    logic [15:0] r_presc;
    logic        r_timer_irq;

    logic        w_accept;
    logic        w_write;
    logic        w_tick;
    clint_sel_e  w_sel;
    logic [15:0] w_presc_next;
    logic [63:0] w_mtime_next;
    logic [63:0] w_cmp_next;
    logic        w_msip_next;
    logic [31:0] w_rdata_mux;
    logic        w_unused;

    // Address bits outside addr[15:2] are don't-care inside the window
    assign w_unused = ^{addr[31:16], addr[1:0]};

    // A valid seen while the response pulse is out is not a new request
    assign w_accept = valid & ~r_ready;
    assign w_write  = w_accept & (wstrb != '0);
    assign w_sel    = clint_decode({addr[15:2], 2'b00});
    assign w_tick   = (r_presc == 16'(PRESCALE - 1));

    // Next-state for prescaler, mtime, mtimecmp and msip; bus writes override the tick
    always_comb begin
        w_presc_next = w_tick ? '0 : r_presc + 16'd1;
        w_mtime_next = w_tick ? r_mtime + 64'd1 : r_mtime;
        w_cmp_next   = r_mtimecmp;
        w_msip_next  = r_msip;
        if (w_write) begin
            case (w_sel)
                SEL_MSIP:    if (wstrb[0]) w_msip_next = wdata[0];
                SEL_CMP_LO:  w_cmp_next[31:0]  = byte_merge(r_mtimecmp[31:0], wdata, wstrb);
                SEL_CMP_HI:  w_cmp_next[63:32] = byte_merge(r_mtimecmp[63:32], wdata, wstrb);
                SEL_TIME_LO: w_mtime_next = {r_mtime[63:32], byte_merge(r_mtime[31:0], wdata, wstrb)};
                SEL_TIME_HI: w_mtime_next = {byte_merge(r_mtime[63:32], wdata, wstrb), r_mtime[31:0]};
                default:     ;
            endcase
        end
    end

    // Read mux over pre-write, pre-increment register values
    always_comb begin
        w_rdata_mux = '0;
        case (w_sel)
            SEL_MSIP:    w_rdata_mux = {31'b0, r_msip};
            SEL_CMP_LO:  w_rdata_mux = r_mtimecmp[31:0];
            SEL_CMP_HI:  w_rdata_mux = r_mtimecmp[63:32];
            SEL_TIME_LO: w_rdata_mux = r_mtime[31:0];
            SEL_TIME_HI: w_rdata_mux = r_mtime[63:32];
            default:     w_rdata_mux = '0;
        endcase
    end

    // State registers, response pulse and registered timer compare
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ready     <= 1'b0;
            r_rdata     <= '0;
            r_mtime     <= '0;
            r_mtimecmp  <= '1;
            r_msip      <= 1'b0;
            r_presc     <= '0;
            r_timer_irq <= 1'b0;
        end else begin
            r_ready     <= w_accept;
            if (w_accept) r_rdata <= w_rdata_mux;
            r_mtime     <= w_mtime_next;
            r_mtimecmp  <= w_cmp_next;
            r_msip      <= w_msip_next;
            r_presc     <= w_presc_next;
            r_timer_irq <= (w_mtime_next >= w_cmp_next);
        end
    end

    assign ready     = r_ready;
    assign rdata     = r_rdata;
    assign timer_irq = r_timer_irq;
    assign soft_irq  = r_msip;

endmodule

// File: tb/tb_vigna_clint.sv
// Randomized bench for vigna_clint against a cycle-level behavioural model of
// the register map, handshake and mtime/mtimecmp rules.
module tb_vigna_clint;

    localparam int unsigned PS = 1;

    logic        clk;
    logic        resetn;
    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        timer_irq;
    logic        soft_irq;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic        m_msip;
    logic        m_irq;
    logic        m_ready;
    logic [31:0] m_rdata;
    int unsigned m_presc;

    vigna_clint #(.PRESCALE(PS)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .valid     (valid),
        .ready     (ready),
        .addr      (addr),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .rdata     (rdata),
        .timer_irq (timer_irq),
        .soft_irq  (soft_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] apply_bytes(input logic [31:0] old_v, input logic [31:0] d,
                                                input logic [3:0] s);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_mtime = 64'd0;
        m_cmp   = '1;
        m_msip  = 1'b0;
        m_irq   = 1'b0;
        m_ready = 1'b0;
        m_rdata = 32'd0;
        m_presc = 0;
    endtask

    // One rising edge of the reference: decide from the inputs visible at the edge
    task automatic model_step();
        logic [63:0] t_n, c_n;
        logic        s_n, acc;
        logic [15:0] off;
        if (!resetn) begin
            model_reset();
            return;
        end
        acc = valid && !m_ready;
        off = {addr[15:2], 2'b00};
        t_n = m_mtime;
        c_n = m_cmp;
        s_n = m_msip;
        if (m_presc == PS - 1) begin
            t_n = m_mtime + 64'd1;
            m_presc = 0;
        end else begin
            m_presc = m_presc + 1;
        end
        if (acc) begin
            case (off)
                16'h0000: m_rdata = {31'd0, m_msip};
                16'h4000: m_rdata = m_cmp[31:0];
                16'h4004: m_rdata = m_cmp[63:32];
                16'hBFF8: m_rdata = m_mtime[31:0];
                16'hBFFC: m_rdata = m_mtime[63:32];
                default:  m_rdata = 32'd0;
            endcase
            if (wstrb != 4'd0) begin
                case (off)
                    16'h0000: if (wstrb[0]) s_n = wdata[0];
                    16'h4000: c_n[31:0]  = apply_bytes(m_cmp[31:0], wdata, wstrb);
                    16'h4004: c_n[63:32] = apply_bytes(m_cmp[63:32], wdata, wstrb);
                    16'hBFF8: t_n = {m_mtime[63:32], apply_bytes(m_mtime[31:0], wdata, wstrb)};
                    16'hBFFC: t_n = {apply_bytes(m_mtime[63:32], wdata, wstrb), m_mtime[31:0]};
                    default:  ;
                endcase
            end
        end
        m_mtime = t_n;
        m_cmp   = c_n;
        m_msip  = s_n;
        m_irq   = (t_n >= c_n);
        m_ready = acc;
    endtask

    task automatic compare_all();
        check_val("ready", ready, m_ready);
        check_val("rdata", rdata, m_rdata);
        check_val("timer_irq", timer_irq, m_irq);
        check_val("soft_irq", soft_irq, m_msip);
    endtask

    // Advance one clock: model at the edge, compare on the falling edge
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic bus_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              output logic [31:0] rd, output logic t_irq, output logic s_irq);
        addr  = a;
        wdata = d;
        wstrb = s;
        valid = 1'b1;
        cycle();
        rd    = rdata;
        t_irq = timer_irq;
        s_irq = soft_irq;
        check_val("bus_ready_pulse", ready, 1'b1);
        valid = 1'b0;
        wstrb = 4'd0;
        cycle();
    endtask

    initial begin
        logic [31:0] rd;
        logic        ti, si;
        logic [31:0] r32, hi_a;
        logic [15:0] off;
        int          n, hold, gap, pick;
        logic [15:0] offs [5];

        offs[0] = 16'h0000; offs[1] = 16'h4000; offs[2] = 16'h4004;
        offs[3] = 16'hBFF8; offs[4] = 16'hBFFC;

        resetn = 1'b0;
        valid  = 1'b0;
        addr   = 32'd0;
        wdata  = 32'd0;
        wstrb  = 4'd0;
        model_reset();

        // T1 reset values and first read of mtime
        repeat (3) cycle();
        check_val("t1_ready", ready, 1'b0);
        check_val("t1_timer_irq", timer_irq, 1'b0);
        check_val("t1_soft_irq", soft_irq, 1'b0);
        resetn = 1'b1;
        bus_access(32'h0200_BFF8, 32'd0, 4'd0, rd, ti, si);
        check_val("t1_mtime_small", (rd < 32'd8), 1'b1);

        // T2 software interrupt bit
        bus_access(32'h0000_0000, 32'h0000_0001, 4'hF, rd, ti, si);
        check_val("t2_soft_set", si, 1'b1);
        bus_access(32'h0000_0000, 32'd0, 4'd0, rd, ti, si);
        check_val("t2_read1", rd, 32'h1);
        bus_access(32'h0000_0000, 32'hFFFF_FFFE, 4'hF, rd, ti, si);
        check_val("t2_soft_clr", si, 1'b0);
        bus_access(32'h0000_0000, 32'd0, 4'd0, rd, ti, si);
        check_val("t2_read0", rd, 32'h0);

        // T3 timer compare rises at mtime == 50, clears on compare rewrite
        bus_access(32'h0000_4004, 32'd0, 4'hF, rd, ti, si);
        bus_access(32'h0000_4000, 32'd50, 4'hF, rd, ti, si);
        check_val("t3_irq_low", ti, 1'b0);
        n = 0;
        while (!timer_irq && n < 200) begin
            cycle();
            n++;
        end
        check_val("t3_irq_rise", timer_irq, 1'b1);
        bus_access(32'h0000_BFF8, 32'd0, 4'd0, rd, ti, si);
        check_val("t3_mtime_at_rise", rd, 32'd50);
        bus_access(32'h0000_4000, 32'hFFFF_FFFF, 4'hF, rd, ti, si);
        check_val("t3_irq_clear", ti, 1'b0);

        // T4 carry from low into high word
        bus_access(32'h0000_BFF8, 32'hFFFF_FFFE, 4'hF, rd, ti, si);
        bus_access(32'h0000_BFFC, 32'd0, 4'hF, rd, ti, si);
        bus_access(32'h0000_BFFC, 32'd0, 4'd0, rd, ti, si);
        check_val("t4_hi", rd, 32'd1);
        bus_access(32'h0000_BFF8, 32'd0, 4'd0, rd, ti, si);
        check_val("t4_lo", rd, 32'd2);

        // T5 byte strobes into mtimecmp low word
        bus_access(32'h0000_4000, 32'hAABB_CCDD, 4'b0101, rd, ti, si);
        bus_access(32'h0000_4000, 32'd0, 4'd0, rd, ti, si);
        check_val("t5_strobe", rd, 32'hFFBB_FFDD);

        // T6 unmapped read, held valid, reset during the ready pulse
        bus_access(32'h0000_1234, 32'd0, 4'd0, rd, ti, si);
        check_val("t6_unmapped", rd, 32'd0);
        check_val("t6_hold_c0", ready, 1'b0);
        addr  = 32'h0000_0000;
        wstrb = 4'd0;
        valid = 1'b1;
        cycle();
        check_val("t6_hold_c1", ready, 1'b1);
        cycle();
        check_val("t6_hold_c2", ready, 1'b0);
        cycle();
        check_val("t6_hold_c3", ready, 1'b1);
        #1;
        resetn = 1'b0;
        valid  = 1'b0;
        model_reset();
        #1;
        check_val("t6_reset_ready", ready, 1'b0);
        compare_all();
        repeat (2) cycle();
        resetn = 1'b1;
        bus_access(32'h0000_4004, 32'd0, 4'd0, rd, ti, si);
        check_val("t6_post_reset_cmp", rd, 32'hFFFF_FFFF);

        // Randomized traffic against the model
        for (int t = 0; t < 300; t++) begin
            pick = $urandom_range(0, 5);
            if (pick == 5) begin
                r32 = $urandom();
                off = r32[15:0];
            end else begin
                off = offs[pick];
            end
            hi_a = $urandom();
            r32  = $urandom();
            addr = {hi_a[31:16], off[15:2], r32[1:0]};
            r32  = $urandom();
            wstrb = ($urandom_range(0, 9) < 4) ? 4'd0 : r32[3:0];
            wdata = $urandom();
            if ((off == 16'h4004 || off == 16'hBFFC) && $urandom_range(0, 3) != 0)
                wdata = $urandom_range(0, 2);
            hold  = ($urandom_range(0, 4) == 0) ? $urandom_range(2, 4) : 1;
            valid = 1'b1;
            for (int h = 0; h < hold; h++) cycle();
            valid = 1'b0;
            wstrb = 4'd0;
            gap = $urandom_range(0, 3);
            cycle();
            for (int g = 0; g < gap; g++) cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
